// File: rtl/cpu_state_sequencer_pkg.sv
// Shared CPU definitions: state encoding, reset vector and opcode constants
// used by the instruction sequencer and the control decoder.
package cpu_state_sequencer_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OPC_W = 6;

    localparam logic [XLEN-1:0] RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [XLEN-1:0] PC_STEP      = 32'd4;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_LOAD  = 3'd1,
        ST_MEM   = 3'd2,
        ST_EXEC  = 3'd3,
        ST_HALT  = 3'd4
    } cpu_state_e;

    localparam logic [OPC_W-1:0] OP_LB  = 6'd32;
    localparam logic [OPC_W-1:0] OP_LH  = 6'd33;
    localparam logic [OPC_W-1:0] OP_LWL = 6'd34;
    localparam logic [OPC_W-1:0] OP_LW  = 6'd35;
    localparam logic [OPC_W-1:0] OP_LBU = 6'd36;
    localparam logic [OPC_W-1:0] OP_LHU = 6'd37;
    localparam logic [OPC_W-1:0] OP_LWR = 6'd38;
    localparam logic [OPC_W-1:0] OP_SB  = 6'd40;
    localparam logic [OPC_W-1:0] OP_SH  = 6'd41;
    localparam logic [OPC_W-1:0] OP_SW  = 6'd43;

    // True for opcodes that perform a bus access in MEM and may therefore stall there.
    function automatic logic is_mem_op(input logic [OPC_W-1:0] opc);
        logic r;
        r = 1'b0;
        case (opc)
            OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR,
            OP_SB, OP_SH, OP_SW: r = 1'b1;
            default:             r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cpu_state_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/LOAD/MEM/EXEC with bus stalls,
// a single branch delay slot and a halt on reaching pc 0.
module cpu_state_sequencer
    import cpu_state_sequencer_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            waitrequest,
    input  logic [XLEN-1:0] readdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic [2:0]      state,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic            active
);

    cpu_state_e      state_q, state_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pending_q, pending_d;
    logic [XLEN-1:0] pending_target_q, pending_target_d;
    logic            active_q, active_d;
    logic [XLEN-1:0] pc_next;

    // A latched redirect takes effect one instruction later (delay slot).
    assign pc_next = pending_q ? pending_target_q : pc_q + PC_STEP;

    always_comb begin
        state_d          = state_q;
        instr_d          = instr_q;
        pc_d             = pc_q;
        pending_d        = pending_q;
        pending_target_d = pending_target_q;
        active_d         = active_q;

        case (state_q)
            ST_FETCH: begin
                if (!waitrequest) begin
                    instr_d = readdata;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_MEM;
            ST_MEM: begin
                if (!(waitrequest && is_mem_op(instr_q[XLEN-1 -: OPC_W]))) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                pc_d = pc_next;
                // A redirect from the delay-slot instruction itself is dropped.
                if (pending_q) begin
                    pending_d = 1'b0;
                end else if (redirect) begin
                    pending_d        = 1'b1;
                    pending_target_d = redirect_target;
                end
                if (pc_next == '0) begin
                    state_d  = ST_HALT;
                    active_d = 1'b0;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_FETCH;
            instr_q          <= '0;
            pc_q             <= RESET_VECTOR;
            pending_q        <= 1'b0;
            pending_target_q <= '0;
            active_q         <= 1'b1;
        end else begin
            state_q          <= state_d;
            instr_q          <= instr_d;
            pc_q             <= pc_d;
            pending_q        <= pending_d;
            pending_target_q <= pending_target_d;
            active_q         <= active_d;
        end
    end

    assign state  = state_q;
    assign instr  = instr_q;
    assign pc     = pc_q;
    assign active = active_q;

endmodule

// File: tb/tb_cpu_state_sequencer.sv
// Directed bench for cpu_state_sequencer: expected register values are queued
// as each step is driven and checked after the following clock edge.
module tb_cpu_state_sequencer;

    logic        clk;
    logic        reset;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [2:0]  state;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        active;

    typedef struct {
        logic [2:0]  st;
        logic [31:0] p;
        logic [31:0] ir;
        logic        act;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_MEM   = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;
    localparam logic [31:0] RV     = 32'hBFC0_0000;

    cpu_state_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .waitrequest     (waitrequest),
        .readdata        (readdata),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .state           (state),
        .instr           (instr),
        .pc              (pc),
        .active          (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input logic [2:0] st, input logic [31:0] p, input logic [31:0] ir,
                            input logic act, input string tag);
        exp_t e;
        e.st = st; e.p = p; e.ir = ir; e.act = act; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        n_tests++;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=0 expected>0");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            assert (state === e.st) else begin
                n_fail++;
                $error("FAIL %s.state observed=%0d expected=%0d", e.tag, state, e.st);
            end
            n_tests++;
            assert (pc === e.p) else begin
                n_fail++;
                $error("FAIL %s.pc observed=%h expected=%h", e.tag, pc, e.p);
            end
            n_tests++;
            assert (instr === e.ir) else begin
                n_fail++;
                $error("FAIL %s.instr observed=%h expected=%h", e.tag, instr, e.ir);
            end
            n_tests++;
            assert (active === e.act) else begin
                n_fail++;
                $error("FAIL %s.active observed=%b expected=%b", e.tag, active, e.act);
            end
        end
    endtask

    // Drive one cycle of inputs, queue the post-edge expectation, then check it.
    task automatic step(input logic w, input logic [31:0] rd, input logic rdr, input logic [31:0] tgt,
                        input logic [2:0] st, input logic [31:0] p, input logic [31:0] ir,
                        input logic act, input string tag);
        waitrequest = w; readdata = rd; redirect = rdr; redirect_target = tgt;
        push_exp(st, p, ir, act, tag);
        @(posedge clk); #1;
        check_out();
    endtask

    // One unstalled instruction; redirect is offered only during EXEC.
    task automatic instr4(input logic [31:0] rd, input logic rdr, input logic [31:0] tgt,
                          input logic [31:0] p_cur, input logic [31:0] p_nxt,
                          input logic [2:0] st_end, input string tag);
        step(1'b0, rd, 1'b0, 32'h0, S_LOAD, p_cur, rd, 1'b1, {tag, "_load"});
        step(1'b0, rd, 1'b0, 32'h0, S_MEM,  p_cur, rd, 1'b1, {tag, "_mem"});
        step(1'b0, rd, 1'b0, 32'h0, S_EXEC, p_cur, rd, 1'b1, {tag, "_exec"});
        step(1'b0, rd, rdr, tgt, st_end, p_nxt, rd, (st_end == S_HALT) ? 1'b0 : 1'b1, {tag, "_next"});
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        push_exp(S_FETCH, RV, 32'h0, 1'b1, "reset_hold");
        check_out();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; waitrequest = 1'b0; readdata = 32'h0; redirect = 1'b0; redirect_target = 32'h0;
        @(posedge clk); #1;
        apply_reset();

        // Basic ADDIU pass, no stalls.
        instr4(32'h2402_0005, 1'b0, 32'h0, RV, RV + 32'h4, S_FETCH, "addiu");

        // FETCH stall: IR must not load while waitrequest=1.
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h8C43_0000, 1'b0, 32'h0, S_FETCH, RV + 32'h4, 32'h2402_0005, 1'b1, "fetch_stall");
        step(1'b0, 32'h8C43_0000, 1'b0, 32'h0, S_LOAD, RV + 32'h4, 32'h8C43_0000, 1'b1, "lw_load");
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, S_MEM,  RV + 32'h4, 32'h8C43_0000, 1'b1, "lw_mem0");
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, S_MEM,  RV + 32'h4, 32'h8C43_0000, 1'b1, "lw_mem1");
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, S_MEM,  RV + 32'h4, 32'h8C43_0000, 1'b1, "lw_mem2");
        step(1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0, S_EXEC, RV + 32'h4, 32'h8C43_0000, 1'b1, "lw_exec");
        step(1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0, S_FETCH, RV + 32'h8, 32'h8C43_0000, 1'b1, "lw_next");

        // Non-memory opcode leaves MEM immediately even with waitrequest=1.
        step(1'b0, 32'h0000_0000, 1'b0, 32'h0, S_LOAD, RV + 32'h8, 32'h0, 1'b1, "nop_load");
        step(1'b1, 32'h0000_0000, 1'b0, 32'h0, S_MEM,  RV + 32'h8, 32'h0, 1'b1, "nop_mem");
        step(1'b1, 32'h0000_0000, 1'b0, 32'h0, S_EXEC, RV + 32'h8, 32'h0, 1'b1, "nop_exec");
        step(1'b0, 32'h0000_0000, 1'b0, 32'h0, S_FETCH, RV + 32'hC, 32'h0, 1'b1, "nop_next");

        // Branch at 0xBFC00010, delay slot ignores its own redirect.
        instr4(32'h0000_0021, 1'b0, 32'h0, RV + 32'hC, RV + 32'h10, S_FETCH, "pre_br");
        instr4(32'h1000_0003, 1'b1, 32'h0000_1000, RV + 32'h10, RV + 32'h14, S_FETCH, "beq");
        instr4(32'h0000_0000, 1'b1, 32'h0000_2000, RV + 32'h14, 32'h0000_1000, S_FETCH, "dslot");
        step(1'b0, 32'h2402_0001, 1'b1, 32'h0000_3000, S_LOAD, 32'h0000_1000, 32'h2402_0001, 1'b1, "tgt_load");
        step(1'b0, 32'h2402_0001, 1'b1, 32'h0000_3000, S_MEM,  32'h0000_1000, 32'h2402_0001, 1'b1, "tgt_mem");
        step(1'b0, 32'h2402_0001, 1'b1, 32'h0000_3000, S_EXEC, 32'h0000_1000, 32'h2402_0001, 1'b1, "tgt_exec");
        step(1'b0, 32'h2402_0001, 1'b0, 32'h0000_3000, S_FETCH, 32'h0000_1004, 32'h2402_0001, 1'b1, "tgt_next");

        // JR to 0: delay slot runs, then HALT sticks under random inputs.
        instr4(32'h03E0_0008, 1'b1, 32'h0000_0000, 32'h0000_1004, 32'h0000_1008, S_FETCH, "jr0");
        instr4(32'h2402_0007, 1'b0, 32'h0, 32'h0000_1008, 32'h0000_0000, S_HALT, "jr0_dslot");
        for (int i = 0; i < 20; i++)
            step(1'($urandom), $urandom, 1'($urandom), $urandom, S_HALT, 32'h0, 32'h2402_0007, 1'b0, "halt_hold");

        // pc+4 wraps from 0xFFFFFFFC to 0 and halts.
        apply_reset();
        instr4(32'h1000_0001, 1'b1, 32'hFFFF_FFF8, RV, RV + 32'h4, S_FETCH, "wrap_br");
        instr4(32'h0000_0000, 1'b0, 32'h0, RV + 32'h4, 32'hFFFF_FFF8, S_FETCH, "wrap_ds");
        instr4(32'h0000_0000, 1'b0, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, S_FETCH, "wrap_a");
        instr4(32'h0000_0000, 1'b0, 32'h0, 32'hFFFF_FFFC, 32'h0000_0000, S_HALT, "wrap_b");

        // Async reset in a MEM stall with a redirect pending.
        apply_reset();
        instr4(32'h1000_0001, 1'b1, 32'h0000_5000, RV, RV + 32'h4, S_FETCH, "pend_br");
        step(1'b0, 32'h8C43_0000, 1'b0, 32'h0, S_LOAD, RV + 32'h4, 32'h8C43_0000, 1'b1, "rst_lw_load");
        step(1'b1, 32'h8C43_0000, 1'b0, 32'h0, S_MEM,  RV + 32'h4, 32'h8C43_0000, 1'b1, "rst_lw_mem0");
        step(1'b1, 32'h8C43_0000, 1'b0, 32'h0, S_MEM,  RV + 32'h4, 32'h8C43_0000, 1'b1, "rst_lw_mem1");
        #2 reset = 1'b1;
        #1;
        push_exp(S_FETCH, RV, 32'h0, 1'b1, "async_rst");
        check_out();
        @(posedge clk); #1;
        reset = 1'b0;
        instr4(32'h2402_0005, 1'b0, 32'h0, RV, RV + 32'h4, S_FETCH, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cpu_state_sequencer.md
CPU_STATE_SEQUENCER -- requirements
Module: cpu_state_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port waitrequest, input, 1 bit: bus stall for the current read or write.
REQ-004 SHALL have port readdata, input, 32 bits: bus read data, valid when waitrequest=0.
REQ-005 SHALL have port redirect, input, 1 bit: branch taken, or jump/jumpreg, resolved in EXEC.
REQ-006 SHALL have port redirect_target, input, 32 bits: target address, sampled in EXEC when redirect=1.
REQ-007 SHALL have port state, output, 3 bits: FETCH=0, LOAD=1, MEM=2, EXEC=3, HALT=4.
REQ-008 SHALL have port instr, output, 32 bits: instruction register (IR).
REQ-009 SHALL have port pc, output, 32 bits: address of the instruction being fetched or executed.
REQ-010 SHALL have port active, output, 1 bit: 1 until HALT is entered.

Function
REQ-011 SHALL sequence FETCH -> LOAD -> MEM -> EXEC -> FETCH for every instruction.
REQ-012 SHALL hold FETCH while waitrequest=1 and advance to LOAD on the first cycle with waitrequest=0.
REQ-013 SHALL capture readdata into IR on the FETCH->LOAD transition; IR SHALL stay stable through LOAD, MEM and EXEC.
REQ-014 SHALL spend exactly one cycle in LOAD (decode/address calculation).
REQ-015 SHALL, in MEM, hold while waitrequest=1 only if IR opcode is a load (32-38) or store (40,41,43); any other opcode leaves MEM after exactly one cycle regardless of waitrequest.
REQ-016 SHALL spend exactly one cycle in EXEC; pc update and halt decision occur on its exit edge.
REQ-017 SHALL implement one branch delay slot with an internal pending-target register and pending flag:
- on the EXEC exit edge, next pc = pending ? pending_target : pc+4;
- pending is set with pending_target=redirect_target when redirect=1 and pending=0 (see REQ-018);
- pending is cleared when it was set and has now been consumed.
REQ-018 SHALL ignore redirect when redirect=1 arrives while pending=1 (branch in a delay slot): no new target is latched.
REQ-019 SHALL enter HALT instead of FETCH when the next pc computed on the EXEC exit edge equals 0x00000000; pc SHALL be updated to 0.
REQ-020 SHALL remain in HALT with active=0 until reset, ignoring waitrequest and redirect.
REQ-021 SHALL compute pc+4 modulo 2^32 (0xFFFFFFFC wraps to 0x00000000, which then halts per REQ-019).
REQ-022 SHALL drive state, instr, pc and active directly from registers, with no combinational path from inputs.

Reset
REQ-023 SHALL, on reset assertion at any time (including mid-stall in FETCH or MEM), asynchronously force: state=FETCH, pc=0xBFC00000, instr=0, pending=0, pending_target=0, active=1.
REQ-024 SHALL begin a fresh fetch at 0xBFC00000 on the first rising clk after reset deasserts.

Structure
REQ-025 SHALL import the state encoding (enum FETCH..HALT), the reset vector constant 0xBFC00000 and the opcode constants from the shared cpu package also used by control.
REQ-026 SHALL be a single module with no sub-modules; the delay-slot pending logic SHALL stay inline.

Verification
REQ-027 Reset, then waitrequest=0 and readdata=0x24020005 (ADDIU) -> states 0,1,2,3,0 on consecutive cycles; pc 0xBFC00000 then 0xBFC00004; instr=0x24020005 from LOAD onward.
REQ-028 waitrequest=1 for 3 cycles in FETCH, then LW (0x8C430000) with waitrequest=1 for 2 cycles in MEM -> FETCH lasts 4 cycles, MEM lasts 3 cycles, IR captured once.
REQ-029 MEM with non-memory opcode (0x00000000) and waitrequest=1 -> MEM lasts exactly 1 cycle.
REQ-030 Redirect=1, target 0x00001000 at pc 0xBFC00010 -> next pc 0xBFC00014 (delay slot), following pc 0x00001000; a redirect raised in the delay slot is ignored.
REQ-031 JR to 0 (redirect_target=0), delay slot executes -> state=4, active=0, pc=0; remains there for 20 cycles of random inputs.
REQ-032 Reset asserted mid-MEM stall -> same cycle: state=0, pc=0xBFC00000, active=1, pending cleared.
